// File: rtl/mac16_accum.sv
// Multiply-accumulate stage: registers operand pairs, multiplies them in mul16 and
// accumulates per-frame sums, presenting each frame result on a held valid/ready output.

module mul16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] o
);
    assign o = a * b;
endmodule

module mac16_accum #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             r_state;
    logic               r_s1_valid;
    logic [15:0]        r_s1_a;
    logic [15:0]        r_s1_b;
    logic               r_s1_last;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_acc;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_adv;
    logic               w_xfer;
    logic               w_acc_en;
    logic               w_load;
    logic [31:0]        w_prod;
    logic [ACC_W:0]     w_sum;
    logic [CNT_W-1:0]   w_cnt_n;
    logic               w_ovf_n;

    // A held, unaccepted result stalls the whole pipe.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv && !rst;
    assign w_xfer   = in_valid && in_ready;
    assign w_acc_en = w_adv && r_s1_valid && !clr;
    assign w_load   = w_acc_en && r_s1_last;

    mul16 u_mul16 (
        .a (r_s1_a),
        .b (r_s1_b),
        .o (w_prod)
    );

    assign w_sum   = {1'b0, r_acc} + {{(ACC_W-31){1'b0}}, w_prod};
    assign w_ovf_n = r_ovf || w_sum[ACC_W];
    assign w_cnt_n = (&r_count) ? r_count : r_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_last   <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (clr)
                r_s1_valid <= 1'b0;
            else if (w_adv)
                r_s1_valid <= in_valid;

            if (w_xfer) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_last <= in_last;
            end

            if (clr) begin
                r_acc   <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_acc_en) begin
                if (r_s1_last) begin
                    // Next frame starts clean on the same edge the result loads.
                    r_acc   <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end else begin
                    r_acc   <= w_sum[ACC_W-1:0];
                    r_count <= w_cnt_n;
                    r_ovf   <= w_ovf_n;
                end
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_acc   <= w_sum[ACC_W-1:0];
                r_out_count <= w_cnt_n;
                r_out_ovf   <= w_ovf_n;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE, ACCUM: begin
                    if (w_load)
                        r_state <= HOLD;
                    else if (clr)
                        r_state <= IDLE;
                    else if (w_acc_en)
                        r_state <= ACCUM;
                end
                HOLD: begin
                    if (w_load)
                        r_state <= HOLD;
                    else if (out_ready)
                        r_state <= (w_acc_en || (r_count != '0 && !clr)) ? ACCUM : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mac16_accum.sv
// Self-checking bench for mac16_accum: directed scenarios plus randomized frames
// scored against a frame-level arithmetic model.

module tb_mac16_accum;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_acc;
    logic [7:0]  out_count;
    logic        out_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Frame-level reference: true sum of products, wrapped and saturated at result time.
    longint unsigned m_sum = 0;
    int              m_cnt = 0;
    logic [39:0]     exp_acc[$];
    int              exp_cnt[$];
    logic            exp_ovf[$];

    mac16_accum #(.ACC_W(40), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                m_sum = m_sum + 64'(in_a) * 64'(in_b);
                m_cnt = m_cnt + 1;
                if (in_last) begin
                    exp_acc.push_back(m_sum[39:0]);
                    exp_cnt.push_back(m_cnt > 255 ? 255 : m_cnt);
                    exp_ovf.push_back((m_sum >> 40) != 0);
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_acc.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got acc=%h count=%0d, required no result", out_acc, out_count);
                end else begin
                    logic [39:0] ea;
                    int          ec;
                    logic        eo;
                    ea = exp_acc.pop_front();
                    ec = exp_cnt.pop_front();
                    eo = exp_ovf.pop_front();
                    n_checks += 2;
                    if (out_acc !== ea) begin
                        n_fail++;
                        $display("FAIL result_acc: got %h, required %h", out_acc, ea);
                    end
                    if (out_count !== 8'(ec)) begin
                        n_fail++;
                        $display("FAIL result_count: got %0d, required %0d", out_count, ec);
                    end
                    if (out_ovf !== eo) begin
                        n_fail++;
                        $display("FAIL result_ovf: got %b, required %b", out_ovf, eo);
                    end
                    $display("result acc=%h count=%0d ovf=%b", out_acc, out_count, out_ovf);
                end
            end
        end
    end

    task automatic model_drop_frame();
        m_sum = 0;
        m_cnt = 0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [39:0] acc,
                             input logic [7:0] cnt, input logic ovf);
        n_checks++;
        if (out_valid !== v || out_acc !== acc || out_count !== cnt || out_ovf !== ovf) begin
            n_fail++;
            $display("FAIL %s: got v=%b acc=%h cnt=%0d ovf=%b, required v=%b acc=%h cnt=%0d ovf=%b",
                     name, out_valid, out_acc, out_count, out_ovf, v, acc, cnt, ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        end
        check_out("reset_outputs", 1'b0, 40'h0, 8'd0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_in_ready: got %b, required 1", in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_frame();
        out_ready = 1'b1;
        send_pair(16'd3, 16'd4, 1'b0);
        send_pair(16'd5, 16'd6, 1'b0);
        send_pair(16'd7, 16'd8, 1'b1);
        in_valid = 1'b0;
        check_out("basic_latency_not_early", 1'b0, 40'h0, 8'd0, 1'b0);
        idle(1);
        check_out("basic_result", 1'b1, 40'd98, 8'd3, 1'b0);
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: out_valid=%b, required 0", out_valid);
        end
        $display("test_basic_frame done");
    endtask

    task automatic test_single_max();
        send_pair(16'hFFFF, 16'hFFFF, 1'b1);
        idle(1);
        check_out("single_max", 1'b1, 40'hFFFE0001, 8'd1, 1'b0);
        idle(1);
        $display("test_single_max done");
    endtask

    task automatic test_back_to_back_saturate();
        int c0;
        c0 = cyc;
        for (int i = 0; i < 257; i++)
            send_pair(16'hFFFF, 16'hFFFF, i == 256);
        in_valid = 1'b0;
        n_checks++;
        if (cyc - c0 !== 257) begin
            n_fail++;
            $display("FAIL throughput: got %0d cycles for 257 pairs, required 257", cyc - c0);
        end
        idle(1);
        check_out("saturate_wrap", 1'b1, 40'h00FDFE0101, 8'd255, 1'b1);
        idle(1);
        $display("test_back_to_back_saturate done");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_pair(16'd2, 16'd2, 1'b1);
        idle(1);
        check_out("bp_pending", 1'b1, 40'd4, 8'd1, 1'b0);
        in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready_cycle%0d: got %b, required 0", i, in_ready);
            end
            check_out("bp_stable", 1'b1, 40'd4, 8'd1, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(1);
        check_out("bp_next_result", 1'b1, 40'd81, 8'd1, 1'b0);
        idle(1);
        $display("test_backpressure done");
    endtask

    task automatic test_clr();
        out_ready = 1'b0;
        send_pair(16'd5, 16'd5, 1'b1);
        idle(1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check_out("clr_keeps_pending", 1'b1, 40'd25, 8'd1, 1'b0);
        out_ready = 1'b1;
        idle(1);
        send_pair(16'd2, 16'd3, 1'b0);
        send_pair(16'd4, 16'd5, 1'b0);
        idle(1);
        clr = 1'b1;
        model_drop_frame();
        @(posedge clk);
        #1;
        clr = 1'b0;
        send_pair(16'd1, 16'd1, 1'b1);
        idle(1);
        check_out("clr_fresh_frame", 1'b1, 40'd1, 8'd1, 1'b0);
        idle(1);
        $display("test_clr done");
    endtask

    task automatic test_rst_mid_frame();
        out_ready = 1'b1;
        send_pair(16'd1, 16'd2, 1'b0);
        send_pair(16'd3, 16'd4, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_drop_frame();
        exp_acc.delete(); exp_cnt.delete(); exp_ovf.delete();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_in_ready: got %b, required 0", in_ready);
        end
        check_out("rst_mid_outputs", 1'b0, 40'h0, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_pair(16'd6, 16'd7, 1'b1);
        idle(1);
        check_out("rst_mid_next_frame", 1'b1, 40'd42, 8'd1, 1'b0);
        idle(1);
        $display("test_rst_mid_frame done");
    endtask

    task automatic test_random();
        bit done = 1'b0;
        int waited = 0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) begin
                        send_pair(16'($urandom), 16'($urandom), k == len - 1);
                        if ($urandom_range(0, 3) == 0)
                            idle($urandom_range(1, 2));
                    end
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        while (exp_acc.size() != 0 && waited < 50) begin
            idle(1);
            waited++;
        end
        idle(2);
        n_checks++;
        if (exp_acc.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d results outstanding, required 0", exp_acc.size());
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_single_max();
        test_back_to_back_saturate();
        test_backpressure();
        test_clr();
        test_rst_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
